// File: rtl/rsa_mont_mul.sv
// rsa_mont_mul -- radix-2 Montgomery multiplier for the 256-bit RSA datapath.
//
// Computes o_result = a * b * 2^-WIDTH mod n with one bit-serial iteration
// per clock. The multiplier a is scanned LSB first. Operands are latched
// when the request is accepted, so the inputs may change freely afterwards.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst     asynchronous reset, active low
//   i_start   request strobe, only looked at while idle
//   i_a       multiplier operand (WIDTH bits)
//   i_b       multiplicand operand (WIDTH bits)
//   i_n       odd modulus (WIDTH bits)
//   o_result  Montgomery product, held until the next request completes
//   o_done    one-cycle pulse, o_result valid in that cycle
//
// Latency: o_done is high WIDTH+1 cycles after the edge that accepts i_start.

module rsa_mont_mul #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    // Final conditional subtraction. m < 2n holds throughout, so a single
    // subtraction brings the result into [0, n).
    function automatic logic [WIDTH-1:0] final_reduce(
        input logic [WIDTH+1:0] m,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH+1:0] n_ext;
        logic [WIDTH+1:0] diff;
        n_ext = {2'b00, n};
        diff  = m - n_ext;
        return (m >= n_ext) ? diff[WIDTH-1:0] : m[WIDTH-1:0];
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] n_q,      n_d;
    logic [WIDTH+1:0] m_q,      m_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q,   done_d;

    // One Montgomery step. t is WIDTH+2 bits wide: with m < 2n and b < n,
    // t < 4n, so the top carry is kept even when n[WIDTH-1] = 1.
    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_sum;
    logic [WIDTH+1:0] m_step;

    always_comb begin
        t_add  = m_q + (a_q[0] ? {2'b00, b_q} : '0);
        t_sum  = t_add[0] ? (t_add + {2'b00, n_q}) : t_add;
        m_step = {1'b0, t_sum[WIDTH+1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    n_d     = i_n;
                    m_d     = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // a is shifted right so the current bit is always a_q[0]
                a_d   = a_q >> 1;
                m_d   = m_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                result_d = final_reduce(m_q, n_q);
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Operand registers are pure data, loaded on accept; no reset needed.
    always_ff @(posedge i_clk) begin
        a_q <= a_d;
        b_q <= b_d;
        n_q <= n_d;
    end

    assign o_result = result_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_rsa_mont_mul.sv
module tb_rsa_mont_mul;

    localparam int W = 256;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] n;
    logic [W-1:0] result;
    logic         done;

    int checks;
    int errors;

    rsa_mont_mul #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_a      (a),
        .i_b      (b),
        .i_n      (n),
        .o_result (result),
        .o_done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge. Drives the request so that the
    // next rising edge is the accept edge, then drops i_start.
    task automatic start_req(input logic [W-1:0] nn, input logic [W-1:0] aa, input logic [W-1:0] bb);
        n     = nn;
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accept edge until o_done is seen (sampled 1 unit
    // after each edge). poke_at > 0 issues a busy request at that cycle;
    // scramble changes the operand inputs every cycle. lat = -1 on timeout.
    task automatic wait_done(input int poke_at, input bit scramble, output int lat);
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (scramble) begin
                a = {8{$urandom}};
                b = {8{$urandom}};
                n = {8{$urandom}};
            end
            if (poke_at > 0 && c == poke_at) begin
                n     = 256'd11;
                a     = 256'd3;
                b     = 256'd4;
                start = 1'b1;
            end
        end
    endtask

    logic [W-1:0] nbig;
    int           lat;
    int           spurious;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        n      = '0;
        nbig   = '1;
        nbig   = nbig - 256'd188;

        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {255'd0, done}, '0);
        check("reset_result", result, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic product: 5*7*2^-256 mod 13 = 35*9 mod 13 = 3
        start_req(256'd13, 256'd5, 256'd7);
        wait_done(0, 1'b0, lat);
        check("basic_latency", 256'(lat), 256'd257);
        check("basic_result", result, 256'd3);
        @(posedge clk);
        #1;
        check("basic_done_pulse", {255'd0, done}, '0);
        check("basic_result_held", result, 256'd3);

        // Zero operand
        start_req(256'd13, 256'd0, 256'd12);
        wait_done(0, 1'b0, lat);
        check("zero_latency", 256'(lat), 256'd257);
        check("zero_result", result, 256'd0);
        @(posedge clk);
        #1;

        // Unit operands: 2^-256 mod 13 = 9
        start_req(256'd13, 256'd1, 256'd1);
        wait_done(0, 1'b0, lat);
        check("unit_result", result, 256'd9);
        @(posedge clk);
        #1;

        // Full-width: a = 189 = 2^256 mod n, so product reduces to b
        start_req(nbig, 256'd189, nbig - 256'd1);
        wait_done(0, 1'b0, lat);
        check("wide_latency", 256'(lat), 256'd257);
        check("wide_result_nm1", result, nbig - 256'd1);
        @(posedge clk);
        #1;
        start_req(nbig, 256'd189, nbig - 256'd2);
        wait_done(0, 1'b0, lat);
        check("wide_result_nm2", result, nbig - 256'd2);
        @(posedge clk);
        #1;

        // Busy request at cycle 100 is ignored
        start_req(256'd13, 256'd5, 256'd7);
        wait_done(100, 1'b0, lat);
        check("busy_latency", 256'(lat), 256'd257);
        check("busy_result", result, 256'd3);

        // Back-to-back: new request issued in the done cycle
        start_req(256'd13, 256'd1, 256'd1);
        check("b2b_done_low", {255'd0, done}, '0);
        wait_done(0, 1'b0, lat);
        check("b2b_latency", 256'(lat + 1), 256'd258);
        check("b2b_result", result, 256'd9);
        @(posedge clk);
        #1;

        // Reset mid-operation
        start_req(256'd13, 256'd5, 256'd7);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_done", {255'd0, done}, '0);
        check("midrst_result", result, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        spurious = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (done) spurious++;
        end
        check("midrst_no_done", 256'(spurious), '0);
        check("midrst_result_idle", result, '0);
        start_req(256'd13, 256'd5, 256'd7);
        wait_done(0, 1'b0, lat);
        check("post_rst_latency", 256'(lat), 256'd257);
        check("post_rst_result", result, 256'd3);
        @(posedge clk);
        #1;

        // Input isolation: inputs scrambled every cycle after accept
        start_req(256'd13, 256'd5, 256'd7);
        wait_done(0, 1'b1, lat);
        check("isol_latency", 256'(lat), 256'd257);
        check("isol_result", result, 256'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
